// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: writeback select, ALU ops, the EX
// control/data bundle and the bubble value loaded on stall, flush and reset.
package id_ex_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WD_ALU     = 2'd0,
    WD_DRAM_RD = 2'd1,
    WD_NPC_PC4 = 2'd2,
    WD_EXT     = 2'd3
  } wd_sel_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_XOR = 3'd3,
    ALU_SLL = 3'd4,
    ALU_SRL = 3'd5,
    ALU_SRA = 3'd6,
    ALU_SUB = 3'd7
  } alu_op_e;

  localparam logic [1:0] BUBBLE_WD_SEL = WD_NPC_PC4;
  localparam logic [2:0] BUBBLE_ALU_OP = ALU_ADD;

  typedef struct packed {
    logic [1:0]        wd_sel;
    logic              alub_sel;
    logic [2:0]        alu_op;
    logic              dram_we;
    logic              rf_we;
    logic [2:0]        branch;
    logic [1:0]        jump;
    logic              have_inst;
    logic [REG_AW-1:0] wR;
    logic [DATA_W-1:0] rD1;
    logic [DATA_W-1:0] rD2;
    logic [DATA_W-1:0] ext;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc4;
  } ex_bundle_t;

  function automatic ex_bundle_t bubble_bundle();
    ex_bundle_t b;
    b        = '0;
    b.wd_sel = BUBBLE_WD_SEL;
    b.alu_op = BUBBLE_ALU_OP;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_operand_fwd.sv
// Combinational forward mux for one ID source operand: EX, then MEM, then WB,
// else the register-file value. x0 and unused operands are never forwarded.
import id_ex_stage_pkg::*;

module operand_fwd (
  input  logic [REG_AW-1:0] i_rs,
  input  logic              i_used,
  input  logic [DATA_W-1:0] i_rd,
  input  logic              i_ex_rf_we,
  input  logic              i_ex_is_load,
  input  logic [REG_AW-1:0] i_ex_wR,
  input  logic [DATA_W-1:0] i_ex_wd,
  input  logic              i_mem_rf_we,
  input  logic [REG_AW-1:0] i_mem_wR,
  input  logic [DATA_W-1:0] i_mem_wd,
  input  logic              i_wb_rf_we,
  input  logic [REG_AW-1:0] i_wb_wR,
  input  logic [DATA_W-1:0] i_wb_wd,
  output logic [DATA_W-1:0] o_fwd
);

  logic w_eligible;

  assign w_eligible = i_used && (i_rs != '0);

  // A load in EX has no data yet; the hazard logic stalls instead.
  always_comb begin
    o_fwd = i_rd;
    if (w_eligible) begin
      if (i_ex_rf_we && !i_ex_is_load && (i_ex_wR == i_rs)) begin
        o_fwd = i_ex_wd;
      end else if (i_mem_rf_we && (i_mem_wR == i_rs)) begin
        o_fwd = i_mem_wd;
      end else if (i_wb_rf_we && (i_wb_wR == i_rs)) begin
        o_fwd = i_wb_wd;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection
// and squash on a taken branch/jump redirect from EX.
import id_ex_stage_pkg::*;

module id_ex_stage (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_id_wd_sel,
  input  logic              i_id_alub_sel,
  input  logic [2:0]        i_id_alu_op,
  input  logic              i_id_dram_we,
  input  logic              i_id_rf_we,
  input  logic [2:0]        i_id_branch,
  input  logic [1:0]        i_id_jump,
  input  logic              i_id_rD1_flag,
  input  logic              i_id_rD2_flag,
  input  logic              i_id_have_inst,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_id_wR,
  input  logic [DATA_W-1:0] i_id_rD1,
  input  logic [DATA_W-1:0] i_id_rD2,
  input  logic [DATA_W-1:0] i_id_ext,
  input  logic [DATA_W-1:0] i_id_pc,
  input  logic [DATA_W-1:0] i_id_pc4,
  input  logic [DATA_W-1:0] i_ex_wd,
  input  logic [DATA_W-1:0] i_mem_wd,
  input  logic [DATA_W-1:0] i_wb_wd,
  input  logic [REG_AW-1:0] i_mem_wR,
  input  logic [REG_AW-1:0] i_wb_wR,
  input  logic              i_mem_rf_we,
  input  logic              i_wb_rf_we,
  input  logic              i_flush,
  output logic              o_stall_if_id,
  output logic [1:0]        o_ex_wd_sel,
  output logic              o_ex_alub_sel,
  output logic [2:0]        o_ex_alu_op,
  output logic              o_ex_dram_we,
  output logic              o_ex_rf_we,
  output logic [2:0]        o_ex_branch,
  output logic [1:0]        o_ex_jump,
  output logic              o_ex_have_inst,
  output logic [REG_AW-1:0] o_ex_wR,
  output logic [DATA_W-1:0] o_ex_rD1,
  output logic [DATA_W-1:0] o_ex_rD2,
  output logic [DATA_W-1:0] o_ex_ext,
  output logic [DATA_W-1:0] o_ex_pc,
  output logic [DATA_W-1:0] o_ex_pc4
);

  ex_bundle_t        r_ex;
  ex_bundle_t        w_id_bundle;
  logic              w_ex_is_load;
  logic              w_hz;
  logic [DATA_W-1:0] w_fwd_rD1;
  logic [DATA_W-1:0] w_fwd_rD2;

  assign w_ex_is_load = r_ex.rf_we && (r_ex.wd_sel == WD_DRAM_RD);

  operand_fwd u_fwd_rs1 (
    .i_rs         (i_id_rs1),
    .i_used       (i_id_rD1_flag),
    .i_rd         (i_id_rD1),
    .i_ex_rf_we   (r_ex.rf_we),
    .i_ex_is_load (w_ex_is_load),
    .i_ex_wR      (r_ex.wR),
    .i_ex_wd      (i_ex_wd),
    .i_mem_rf_we  (i_mem_rf_we),
    .i_mem_wR     (i_mem_wR),
    .i_mem_wd     (i_mem_wd),
    .i_wb_rf_we   (i_wb_rf_we),
    .i_wb_wR      (i_wb_wR),
    .i_wb_wd      (i_wb_wd),
    .o_fwd        (w_fwd_rD1)
  );

  operand_fwd u_fwd_rs2 (
    .i_rs         (i_id_rs2),
    .i_used       (i_id_rD2_flag),
    .i_rd         (i_id_rD2),
    .i_ex_rf_we   (r_ex.rf_we),
    .i_ex_is_load (w_ex_is_load),
    .i_ex_wR      (r_ex.wR),
    .i_ex_wd      (i_ex_wd),
    .i_mem_rf_we  (i_mem_rf_we),
    .i_mem_wR     (i_mem_wR),
    .i_mem_wd     (i_mem_wd),
    .i_wb_rf_we   (i_wb_rf_we),
    .i_wb_wR      (i_wb_wR),
    .i_wb_wd      (i_wb_wd),
    .o_fwd        (w_fwd_rD2)
  );

  assign w_hz = w_ex_is_load && (r_ex.wR != '0) &&
                ((i_id_rD1_flag && (i_id_rs1 == r_ex.wR)) ||
                 (i_id_rD2_flag && (i_id_rs2 == r_ex.wR)));

  // A redirect squashes ID anyway, so holding IF/ID would only lose the new fetch.
  assign o_stall_if_id = w_hz && !i_flush;

  always_comb begin
    w_id_bundle           = '0;
    w_id_bundle.wd_sel    = i_id_wd_sel;
    w_id_bundle.alub_sel  = i_id_alub_sel;
    w_id_bundle.alu_op    = i_id_alu_op;
    w_id_bundle.dram_we   = i_id_dram_we;
    w_id_bundle.rf_we     = i_id_rf_we;
    w_id_bundle.branch    = i_id_branch;
    w_id_bundle.jump      = i_id_jump;
    w_id_bundle.have_inst = i_id_have_inst;
    w_id_bundle.wR        = i_id_wR;
    w_id_bundle.rD1       = w_fwd_rD1;
    w_id_bundle.rD2       = w_fwd_rD2;
    w_id_bundle.ext       = i_id_ext;
    w_id_bundle.pc        = i_id_pc;
    w_id_bundle.pc4       = i_id_pc4;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush || w_hz) begin
      r_ex <= bubble_bundle();
    end else begin
      r_ex <= w_id_bundle;
    end
  end

  assign o_ex_wd_sel    = r_ex.wd_sel;
  assign o_ex_alub_sel  = r_ex.alub_sel;
  assign o_ex_alu_op    = r_ex.alu_op;
  assign o_ex_dram_we   = r_ex.dram_we;
  assign o_ex_rf_we     = r_ex.rf_we;
  assign o_ex_branch    = r_ex.branch;
  assign o_ex_jump      = r_ex.jump;
  assign o_ex_have_inst = r_ex.have_inst;
  assign o_ex_wR        = r_ex.wR;
  assign o_ex_rD1       = r_ex.rD1;
  assign o_ex_rD2       = r_ex.rD2;
  assign o_ex_ext       = r_ex.ext;
  assign o_ex_pc        = r_ex.pc;
  assign o_ex_pc4       = r_ex.pc4;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 5-stage RV32I core, directly downstream of the decode controller. It latches the decoded control bundle and register operands into EX, and forwards EX/MEM/WB results onto the ID operands before latching. It detects load-use hazards, stalling PC and IF/ID for one cycle while inserting a bubble. It also squashes the ID instruction on a taken branch/jump redirect from EX.

## Interface
- DATA_W, 32, operand/PC width
- REG_AW, 5, register index width

- clk  in  1  core clock
- rst_n  in  1  synchronous, active-low reset
- id_wd_sel  in  2  writeback select from controller
- id_alub_sel  in  1  ALU B select
- id_alu_op  in  3  ALU operation
- id_dram_we  in  1  store enable
- id_rf_we  in  1  RF write enable
- id_branch  in  3  branch code
- id_jump  in  2  jump code
- id_rD1_flag, id_rD2_flag  in  1  operand used
- id_have_inst  in  1  valid opcode
- id_rs1, id_rs2, id_wR  in  REG_AW  source/dest indices
- id_rD1, id_rD2  in  DATA_W  RF read data
- id_ext, id_pc, id_pc4  in  DATA_W  immediate, PC, PC+4
- ex_wd, mem_wd, wb_wd  in  DATA_W  writeback value in EX/MEM/WB
- mem_wR, wb_wR  in  REG_AW  dest index in MEM/WB
- mem_rf_we, wb_rf_we  in  1  write enable in MEM/WB
- flush  in  1  taken branch/jump resolved in EX
- stall_if_id  out  1  hold PC and IF/ID (combinational)
- ex_* (wd_sel, alub_sel, alu_op, dram_we, rf_we, branch, jump, have_inst, wR, rD1, rD2, ext, pc, pc4)  out  widths as inputs  registered EX bundle

## Operation
- Bubble: rf_we, dram_we, branch, jump, have_inst = 0. wd_sel = `NPC_PC4`. alu_op = `ADD`. All data fields and wR = 0.
- Load-use hazard (hz), evaluated against the current EX register:
  - ex_rf_we && ex_wd_sel == `DRAM_RD` && ex_wR != 0, and
  - (id_rD1_flag && id_rs1 == ex_wR) || (id_rD2_flag && id_rs2 == ex_wR).
- stall_if_id = hz && !flush.
- Register update each cycle, priority flush > hz > normal:
  - flush or hz: load bubble.
  - normal: load ID bundle, with rD1/rD2 replaced by forwarded values.
- Forwarding per operand, first match wins; never for index 0; only when the corresponding rD*_flag is 1:
  1. EX: ex_rf_we && ex_wR == rs && ex_wd_sel != `DRAM_RD` → ex_wd.
  2. MEM: mem_rf_we && mem_wR == rs → mem_wd.
  3. WB: wb_rf_we && wb_wR == rs → wb_wd.
  4. Otherwise: id_rD*.
- id_have_inst = 0 is latched as-is (the downstream stage ignores it); it is not treated as a hazard source.
- No arithmetic beyond equality compares; all data paths are pass-through at DATA_W.

## Timing
- Reset: on a rising clk with rst_n = 0, the EX register loads a bubble. All ex_* outputs read 0, except wd_sel = `NPC_PC4` and alu_op = `ADD`. stall_if_id follows its equation and is 0 after reset.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- Load-use costs exactly one bubble. In the stall cycle the ID inputs are held upstream. Next cycle the load is in MEM, hz = 0, and the operand is taken via the MEM forward.
- Simultaneous flush and hz: bubble inserted, stall_if_id = 0.
- Back-to-back flush: a bubble every cycle.
- Reset asserted mid-stall: the bubble wins and stall deasserts in the next cycle.

## Structure
- Encodings (`DRAM_RD`, `NPC_PC4`, `ADD`, opcode constants) come from shared param.v. Add `BUBBLE_*` defaults there.
- One sub-module, operand_fwd: combinational 3-source forward mux, instantiated twice (rs1, rs2).
- The EX register and hazard logic stay in id_ex_stage.

## Test plan
- Reset: rst_n = 0 for 2 cycles with arbitrary ID inputs → all ex_* = bubble values, stall_if_id = 0.
- Pass-through: add x3,x1,x2 with rD1 = 5, rD2 = 7, no forwards → next cycle ex_rD1 = 5, ex_rD2 = 7, ex_rf_we = 1, ex_wR = 3.
- Forward priority: rs1 = 4; EX writes x4 with ex_wd = 0x11; MEM writes x4 with 0x22; WB writes x4 with 0x33 → ex_rD1 = 0x11. Drop EX → 0x22. Drop MEM → 0x33. rs1 = 0 with all matching → id_rD1 is used.
- Load-use: lw x5 in EX; ID is add x6,x5,x1 → stall_if_id = 1, EX gets a bubble. Next cycle, with mem_wd = 0x99 and mem_wR = 5 → ex_rD1 = 0x99, stall_if_id = 0.
- Load-use on unused operand: lw x5 in EX; ID is lui x5 (rD1_flag = 0) → no stall.
- Flush vs hazard: flush = 1 together with load-use → bubble, stall_if_id = 0. Flush alone with a valid ID store → ex_dram_we = 0.
